inst_fetch: RTL and testbench

Instruction-fetch front end of the simple MIPS core. It is the initiator side of the instruction ROM interface. It owns the program counter, drives the ROM chip-enable and address, and captures the combinational ROM read data. The captured instructions feed a 2-entry buffer that is presented to the decode stage with a valid/ready handshake, and branch redirects flush the front end.

---
 rtl/inst_fetch.sv | 94 +++++++++
 tb/tb_inst_fetch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the PC, drives the instruction ROM and
// presents fetched words to decode through a 2-entry valid/ready buffer.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [1:0]  count, count_nxt;
    logic        pop;
    logic        can_fetch;

    // Buffer slot 0 is always the head; slot 1 is only meaningful at count 2.
    logic [31:0] inst_q [2];
    logic [31:0] pc_q   [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
            count <= 2'd0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = FETCH;
        pc_nxt    = pc;
        count_nxt = count;
        pop       = (count != 2'd0) && id_ready_i;
        can_fetch = (state == FETCH) && !branch_flag_i && ((count < 2'd2) || pop);

        // A redirect discards the buffer; a concurrent pop has already been taken by decode.
        if (branch_flag_i) begin
            pc_nxt    = {branch_target_i[31:2], 2'b00};
            count_nxt = 2'd0;
        end else if (can_fetch) begin
            pc_nxt = pc + 32'd4;
            if (!pop) begin
                count_nxt = count + 2'd1;
            end
        end else if (pop) begin
            count_nxt = count - 2'd1;
        end
    end

    // Buffer contents carry no reset; count alone says what is valid.
    always_ff @(posedge clk) begin
        if (can_fetch) begin
            if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
                inst_q[0] <= rom_inst_i;
                pc_q[0]   <= pc;
            end else if (count == 2'd1) begin
                inst_q[1] <= rom_inst_i;
                pc_q[1]   <= pc;
            end else begin
                inst_q[0] <= inst_q[1];
                pc_q[0]   <= pc_q[1];
                inst_q[1] <= rom_inst_i;
                pc_q[1]   <= pc;
            end
        end else if (pop) begin
            inst_q[0] <= inst_q[1];
            pc_q[0]   <= pc_q[1];
        end
    end

    assign rom_ce_o   = can_fetch;
    assign rom_addr_o = pc;
    assign id_valid_o = (count != 2'd0);
    assign id_inst_o  = id_valid_o ? inst_q[0] : 32'h0;
    assign id_pc_o    = id_valid_o ? pc_q[0]   : 32'h0;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations (startup, stall, branch, wrap, reset).
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_ready = 1'b1;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        rom_ce;
    logic [31:0] rom_addr, rom_inst, id_inst, id_pc;
    logic        id_valid;

    logic        rst_n2 = 1'b0;
    logic        rom_ce2, id_valid2;
    logic [31:0] rom_addr2, rom_inst2, id_inst2, id_pc2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    assign rom_inst  = rom_word(rom_addr);
    assign rom_inst2 = rom_word(rom_addr2);

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .rom_ce_o(rom_ce), .rom_addr_o(rom_addr),
        .rom_inst_i(rom_inst), .id_valid_o(id_valid), .id_ready_i(id_ready),
        .id_inst_o(id_inst), .id_pc_o(id_pc), .branch_flag_i(branch_flag),
        .branch_target_i(branch_target)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n2), .rom_ce_o(rom_ce2), .rom_addr_o(rom_addr2),
        .rom_inst_i(rom_inst2), .id_valid_o(id_valid2), .id_ready_i(1'b1),
        .id_inst_o(id_inst2), .id_pc_o(id_pc2), .branch_flag_i(1'b0),
        .branch_target_i(32'h0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {inst, pc} plus a PC and a started flag.
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_started = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_pc      = 32'h0;
                m_started = 1'b0;
            end else if (!m_started) begin
                m_started = 1'b1;
                if (branch_flag) m_pc = {branch_target[31:2], 2'b00};
            end else begin
                bit take, fetch;
                take  = (mq.size() > 0) && id_ready;
                fetch = !branch_flag && ((mq.size() < 2) || take);
                if (take) void'(mq.pop_front());
                if (branch_flag) begin
                    mq.delete();
                    m_pc = {branch_target[31:2], 2'b00};
                end else if (fetch) begin
                    mq.push_back('{inst: rom_word(m_pc), pc: m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    initial begin
        forever begin
            logic exp_ce;
            @(negedge clk);
            exp_ce = m_started && !branch_flag &&
                     ((mq.size() < 2) || ((mq.size() > 0) && id_ready));
            chk("m_rom_ce", {31'h0, rom_ce}, {31'h0, exp_ce});
            chk("m_rom_addr", rom_addr, m_pc);
            chk("m_id_valid", {31'h0, id_valid}, {31'h0, mq.size() > 0});
            chk("m_id_inst", id_inst, (mq.size() > 0) ? mq[0].inst : 32'h0);
            chk("m_id_pc", id_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values and startup
        tick(); tick();
        chk("rst_ce", {31'h0, rom_ce}, 32'h0);
        chk("rst_addr", rom_addr, 32'h0);
        chk("rst_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_pc", id_pc, 32'h0);
        rst_n = 1'b1;
        #1 chk("idle_ce", {31'h0, rom_ce}, 32'h0);
        tick();
        chk("e0_ce", {31'h0, rom_ce}, 32'h1);
        chk("e0_addr", rom_addr, 32'h0);
        chk("e0_valid", {31'h0, id_valid}, 32'h0);
        tick();
        chk("s0_pc", id_pc, 32'h0);
        chk("s0_inst", id_inst, 32'h1000_0000);
        tick();
        chk("s1_pc", id_pc, 32'h4);
        chk("s1_inst", id_inst, 32'h1000_0001);
        tick();
        chk("s2_pc", id_pc, 32'h8);

        // Backpressure from a fresh start: fill to 2, stall, then resume
        rst_n = 1'b0;
        id_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("bp_ce", {31'h0, rom_ce}, 32'h0);
        chk("bp_addr", rom_addr, 32'h8);
        chk("bp_head", id_pc, 32'h0);
        tick(); tick();
        chk("bp_ce2", {31'h0, rom_ce}, 32'h0);
        chk("bp_addr2", rom_addr, 32'h8);
        id_ready = 1'b1;
        #1 chk("bp_rel_ce", {31'h0, rom_ce}, 32'h1);
        tick();
        chk("bp_r0", id_pc, 32'h4);
        chk("bp_r0_addr", rom_addr, 32'hC);
        tick();
        chk("bp_r1", id_pc, 32'h8);
        chk("bp_r1_addr", rom_addr, 32'h10);

        // Branch with the buffer full
        id_ready = 1'b0;
        branch_flag = 1'b1;
        branch_target = 32'h0000_0043;
        #1 chk("br_ce", {31'h0, rom_ce}, 32'h0);
        tick();
        branch_flag = 1'b0;
        id_ready = 1'b1;
        #1;
        chk("br_addr", rom_addr, 32'h40);
        chk("br_bubble", {31'h0, id_valid}, 32'h0);
        chk("br_ce2", {31'h0, rom_ce}, 32'h1);
        tick();
        chk("br_pc", id_pc, 32'h40);
        chk("br_inst", id_inst, 32'h1000_0010);

        // Branch together with a pop
        id_ready = 1'b0;
        tick();
        id_ready = 1'b1;
        branch_flag = 1'b1;
        branch_target = 32'h0000_0100;
        #1 chk("bp_head_taken", id_pc, 32'h40);
        tick();
        branch_flag = 1'b0;
        #1;
        chk("bpop_valid", {31'h0, id_valid}, 32'h0);
        chk("bpop_addr", rom_addr, 32'h100);
        tick();
        chk("bpop_pc", id_pc, 32'h100);
        chk("bpop_inst", id_inst, 32'h1000_0040);

        // Held branch, target changes while held
        branch_flag = 1'b1;
        branch_target = 32'h0000_0200;
        tick();
        branch_target = 32'h0000_0307;
        tick();
        branch_flag = 1'b0;
        #1;
        chk("hold_valid", {31'h0, id_valid}, 32'h0);
        chk("hold_addr", rom_addr, 32'h304);
        tick();
        chk("hold_pc", id_pc, 32'h304);
        tick(); tick();

        // Asynchronous reset mid-stream with one entry buffered
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'h0, id_valid}, 32'h0);
        chk("ar_ce", {31'h0, rom_ce}, 32'h0);
        chk("ar_addr", rom_addr, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_e0_addr", rom_addr, 32'h0);
        tick();
        chk("ar_pc", id_pc, 32'h0);
        chk("ar_inst", id_inst, 32'h1000_0000);

        // PC wrap on the second instance
        rst_n2 = 1'b1;
        #1 chk("w_idle_ce", {31'h0, rom_ce2}, 32'h0);
        tick();
        chk("w_addr0", rom_addr2, 32'hFFFF_FFF8);
        chk("w_ce", {31'h0, rom_ce2}, 32'h1);
        tick();
        chk("w_addr1", rom_addr2, 32'hFFFF_FFFC);
        chk("w_pc0", id_pc2, 32'hFFFF_FFF8);
        chk("w_inst0", id_inst2, 32'h4FFF_FFFE);
        tick();
        chk("w_addr2", rom_addr2, 32'h0000_0000);
        chk("w_pc1", id_pc2, 32'hFFFF_FFFC);
        tick();
        chk("w_pc2", id_pc2, 32'h0000_0000);
        chk("w_inst2", id_inst2, 32'h1000_0000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
